// File: rtl/sprite_rom_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// sprite_pkg
// Shared constants and types for the sprite subsystem.
//   SPR_W / SPR_H   : sprite dimensions in pixels (powers of two)
//   N_FRAMES        : number of frames stored back to back in the sprite ROM
//   FRAME_SIZE      : pixels per frame
//   ROM_DEPTH       : total ROM entries
//   pixel_t         : one palette index
//   TRANSPARENT     : palette index returned for rejected (out-of-range) reads
// -----------------------------------------------------------------------------
package sprite_pkg;

    localparam int SPR_W      = 32;
    localparam int SPR_H      = 16;
    localparam int N_FRAMES   = 3;
    localparam int FRAME_SIZE = SPR_W * SPR_H;
    localparam int ROM_DEPTH  = N_FRAMES * FRAME_SIZE;
    localparam int PIX_W      = 4;

    typedef logic [PIX_W-1:0] pixel_t;

    localparam pixel_t TRANSPARENT = '0;

endpackage

// File: rtl/sprite_rom_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin arbiter. Grants the first asserted request at or
// after the round-robin pointer, wrapping modulo N_REQ.
// Ports:
//   i_req    : request bits, one per requester
//   i_rr_ptr : index with highest priority this cycle
//   o_gnt    : one-hot grant, zero when no request
//   o_idx    : index of the granted requester (0 when no grant)
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N_REQ = 2,
    localparam int IW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IW-1:0]    i_rr_ptr,
    output logic [N_REQ-1:0] o_gnt,
    output logic [IW-1:0]    o_idx
);

    always_comb begin : arb
        logic w_found;
        int   w_j;
        o_gnt   = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_j     = 0;
        // Walk the requesters starting at the pointer; first hit wins.
        for (int k = 0; k < N_REQ; k++) begin
            w_j = (int'(i_rr_ptr) + k) % N_REQ;
            if (!w_found && i_req[w_j]) begin
                w_found     = 1'b1;
                o_gnt[w_j]  = 1'b1;
                o_idx       = IW'(w_j);
            end
        end
    end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// -----------------------------------------------------------------------------
// sprite_rom_arbiter
// Shares one synchronous-read sprite ROM between N_REQ renderers. Requests are
// arbitrated round-robin, the linear ROM address is computed and registered,
// and the ROM data is returned two cycles after acceptance, tagged one-hot to
// the requester that issued it.
//
// Handshake: a request transfers on the rising edge where req[i] & gnt[i].
// The requester holds req and its fields stable until granted. gnt is purely
// combinational and never back-pressured by the response side.
//
// Ports:
//   Clk, Reset           : clock, synchronous active-high reset
//   req / gnt            : per-requester request / combinational accept
//   req_frame/req_x/req_y: packed per-requester frame, column, row
//   req_hflip            : (only with SPRITE_ARB_HFLIP_EN) mirror column
//   rom_addr / rom_data  : registered ROM address / data one cycle later
//   rsp_valid            : one-hot single-cycle response strobe
//   rsp_data             : pixel for the strobed requester (0 on error)
//   rsp_err              : response belongs to an out-of-range request
//
// Optional feature macro: SPRITE_ARB_HFLIP_EN (horizontal flip input).
// -----------------------------------------------------------------------------
module sprite_rom_arbiter
    import sprite_pkg::*;
#(
    parameter int N_REQ    = 2,
    parameter int SPR_W    = sprite_pkg::SPR_W,
    parameter int SPR_H    = sprite_pkg::SPR_H,
    parameter int N_FRAMES = sprite_pkg::N_FRAMES,
    parameter int ADDR_W   = 11,
    parameter int DATA_W   = 4,
    localparam int FW      = (N_FRAMES > 1) ? $clog2(N_FRAMES) : 1,
    localparam int XW      = $clog2(SPR_W),
    localparam int YW      = $clog2(SPR_H)
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic [N_REQ-1:0]    req,
    output logic [N_REQ-1:0]    gnt,
    input  logic [N_REQ*FW-1:0] req_frame,
    input  logic [N_REQ*XW-1:0] req_x,
    input  logic [N_REQ*YW-1:0] req_y,
`ifdef SPRITE_ARB_HFLIP_EN
    input  logic [N_REQ-1:0]    req_hflip,
`endif
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [DATA_W-1:0]   rom_data,
    output logic [N_REQ-1:0]    rsp_valid,
    output logic [DATA_W-1:0]   rsp_data,
    output logic                rsp_err
);

    localparam int IW       = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int FRM_PIX  = SPR_W * SPR_H;

    logic [N_REQ-1:0]  w_gnt_raw;
    logic [IW-1:0]     w_idx;
    logic              w_xfer;
    logic [FW-1:0]     w_frame;
    logic [XW-1:0]     w_x;
    logic [YW-1:0]     w_y;
    logic [XW-1:0]     w_col;
    logic              w_err;
    logic [ADDR_W-1:0] w_addr;

    logic [IW-1:0]     r_rr_ptr;
    logic [ADDR_W-1:0] r_rom_addr;
    logic [IW-1:0]     r_s1_tag;
    logic              r_s1_valid;
    logic              r_s1_err;
    logic [N_REQ-1:0]  r_rsp_valid;
    logic              r_rsp_err;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .i_req    (req),
        .i_rr_ptr (r_rr_ptr),
        .o_gnt    (w_gnt_raw),
        .o_idx    (w_idx)
    );

    // Nothing is accepted while reset is held.
    assign gnt    = Reset ? '0 : w_gnt_raw;
    assign w_xfer = |gnt;

    // Fields of the winning requester.
    assign w_frame = req_frame[int'(w_idx)*FW +: FW];
    assign w_x     = req_x[int'(w_idx)*XW +: XW];
    assign w_y     = req_y[int'(w_idx)*YW +: YW];

    // Range check always uses the column as supplied (before any flip).
    assign w_err = (32'(w_frame) >= N_FRAMES) || (32'(w_x) >= SPR_W) ||
                   (32'(w_y) >= SPR_H);

`ifdef SPRITE_ARB_HFLIP_EN
    assign w_col = req_hflip[w_idx] ? (XW'(SPR_W - 1) - w_x) : w_x;
`else
    assign w_col = w_x;
`endif

    // Full-width linear address, truncated to the ROM address width.
    assign w_addr = ADDR_W'(32'(w_frame) * 32'(FRM_PIX) +
                            32'(w_y) * 32'(SPR_W) + 32'(w_col));

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_rr_ptr    <= '0;
            r_rom_addr  <= '0;
            r_s1_tag    <= '0;
            r_s1_valid  <= 1'b0;
            r_s1_err    <= 1'b0;
            r_rsp_valid <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            // Stage 1: ROM address and bookkeeping for the accepted request.
            r_s1_valid <= w_xfer;
            if (w_xfer) begin
                r_rom_addr <= w_err ? '0 : w_addr;
                r_s1_tag   <= w_idx;
                r_s1_err   <= w_err;
                r_rr_ptr   <= (w_idx == IW'(N_REQ - 1)) ? '0 : w_idx + IW'(1);
            end
            // Stage 2: ROM data arrives alongside these registers.
            r_rsp_valid <= r_s1_valid ? (N_REQ'(1) << r_s1_tag) : '0;
            r_rsp_err   <= r_s1_valid & r_s1_err;
        end
    end

    assign rom_addr  = r_rom_addr;
    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;
    assign rsp_data  = r_rsp_err ? DATA_W'(TRANSPARENT) : rom_data;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
module tb_sprite_rom_arbiter;

    localparam int N_REQ    = 2;
    localparam int SPR_W    = 32;
    localparam int SPR_H    = 16;
    localparam int N_FRAMES = 3;
    localparam int ADDR_W   = 11;
    localparam int DATA_W   = 4;
    localparam int FW       = 2;
    localparam int XW       = 5;
    localparam int YW       = 4;
    localparam int W        = N_REQ + 1 + DATA_W;

    // ---------------- clock / reset ----------------
    logic Clk = 1'b0;
    logic Reset;
    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    // ---------------- DUT signals ----------------
    logic [N_REQ-1:0]    req;
    logic [N_REQ-1:0]    gnt;
    logic [N_REQ*FW-1:0] req_frame;
    logic [N_REQ*XW-1:0] req_x;
    logic [N_REQ*YW-1:0] req_y;
`ifdef SPRITE_ARB_HFLIP_EN
    logic [N_REQ-1:0]    req_hflip;
`endif
    logic [ADDR_W-1:0]   rom_addr;
    logic [DATA_W-1:0]   rom_data = '0;
    logic [N_REQ-1:0]    rsp_valid;
    logic [DATA_W-1:0]   rsp_data;
    logic                rsp_err;

    sprite_rom_arbiter #(
        .N_REQ(N_REQ), .SPR_W(SPR_W), .SPR_H(SPR_H), .N_FRAMES(N_FRAMES),
        .ADDR_W(ADDR_W), .DATA_W(DATA_W)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .req       (req),
        .gnt       (gnt),
        .req_frame (req_frame),
        .req_x     (req_x),
        .req_y     (req_y),
`ifdef SPRITE_ARB_HFLIP_EN
        .req_hflip (req_hflip),
`endif
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err)
    );

    // ---------------- ROM model ----------------
    logic [DATA_W-1:0] mem [0:2047];
    always @(posedge Clk) rom_data <= mem[rom_addr];

    // ---------------- scoreboard ----------------
    int checks   = 0;
    int failures = 0;
    logic [W-1:0] exp_q[$];
    int           exp_t_q[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // ---------------- requester state / reference model ----------------
    logic [N_REQ-1:0] tb_req;
    logic [FW-1:0]    tb_frame [N_REQ];
    logic [XW-1:0]    tb_x     [N_REQ];
    logic [YW-1:0]    tb_y     [N_REQ];
    logic             tb_hflip [N_REQ];
    int               m_ptr = 0;

    task automatic drive();
        req = tb_req;
        for (int i = 0; i < N_REQ; i++) begin
            req_frame[i*FW +: FW] = tb_frame[i];
            req_x[i*XW +: XW]     = tb_x[i];
            req_y[i*YW +: YW]     = tb_y[i];
`ifdef SPRITE_ARB_HFLIP_EN
            req_hflip[i]          = tb_hflip[i];
`endif
        end
    endtask

    task automatic set_req(input int i, input int f, input int x, input int y, input bit h);
        tb_req[i]   = 1'b1;
        tb_frame[i] = FW'(f);
        tb_x[i]     = XW'(x);
        tb_y[i]     = YW'(y);
        tb_hflip[i] = h;
    endtask

    // One clock: called just after a falling edge, returns after the next one.
    task automatic step(input bit hold);
        int w, f, x, y, col, a;
        bit err, flip;
        logic [N_REQ-1:0]  exp_gnt;
        logic [N_REQ-1:0]  onehot;
        logic [DATA_W-1:0] d;
        drive();
        #1;
        w = -1;
        for (int k = 0; k < N_REQ; k++)
            if (w < 0 && tb_req[(m_ptr + k) % N_REQ]) w = (m_ptr + k) % N_REQ;
        exp_gnt = '0;
        if (w >= 0) exp_gnt[w] = 1'b1;
        check("gnt", 32'(gnt), 32'(exp_gnt));
        a = 0;
        if (w >= 0) begin
            f = int'(tb_frame[w]);
            x = int'(tb_x[w]);
            y = int'(tb_y[w]);
`ifdef SPRITE_ARB_HFLIP_EN
            flip = tb_hflip[w];
`else
            flip = 1'b0;
`endif
            col = flip ? (SPR_W - 1 - x) : x;
            err = (f >= N_FRAMES) || (x >= SPR_W) || (y >= SPR_H);
            a   = err ? 0 : (f * SPR_W * SPR_H + y * SPR_W + col) % 2048;
            d   = err ? '0 : mem[a];
            onehot = '0;
            onehot[w] = 1'b1;
            exp_q.push_back({onehot, err, d});
            exp_t_q.push_back(cyc + 2);
        end
        @(posedge Clk);
        if (w >= 0) begin
            m_ptr = (w + 1) % N_REQ;
            if (!hold) tb_req[w] = 1'b0;
        end
        @(negedge Clk);
        if (w >= 0) check("rom_addr", 32'(rom_addr), 32'(a));
    endtask

    // ---------------- monitor ----------------
    initial begin
        forever begin
            @(negedge Clk);
            if (!Reset) begin
                if (exp_t_q.size() > 0 && exp_t_q[0] == cyc) begin
                    logic [W-1:0] e;
                    e = exp_q.pop_front();
                    void'(exp_t_q.pop_front());
                    check("rsp", 32'({rsp_valid, rsp_err, rsp_data}), 32'(e));
                end else if (rsp_valid != '0) begin
                    check("rsp_unexpected", 32'(rsp_valid), 32'(0));
                end
            end
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = DATA_W'($urandom_range(0, 15));
        tb_req = '0;
        for (int i = 0; i < N_REQ; i++) begin
            tb_frame[i] = '0; tb_x[i] = '0; tb_y[i] = '0; tb_hflip[i] = 1'b0;
        end
        Reset = 1'b1;
        drive();
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        // Reset state, with requests asserted to show gnt is held off.
        tb_req = '1;
        drive();
        #1;
        check("reset_gnt", 32'(gnt), 32'(0));
        check("reset_rom_addr", 32'(rom_addr), 32'(0));
        check("reset_rsp_valid", 32'(rsp_valid), 32'(0));
        check("reset_rsp_err", 32'(rsp_err), 32'(0));
        @(negedge Clk);
        Reset = 1'b0;

        // Contention straight out of reset: alternating grants.
        set_req(0, 0, 3, 1, 1'b0);
        set_req(1, 2, 9, 7, 1'b0);
        repeat (4) step(1'b1);
        tb_req = '0;
        step(1'b0);

        // Single request, frame 1 x 5 y 2 -> address 581.
        set_req(0, 1, 5, 2, 1'b0);
        step(1'b0);
        // Out-of-range frame.
        set_req(1, 3, 7, 3, 1'b0);
        step(1'b0);
        // Largest legal address.
        set_req(0, 2, 31, 15, 1'b0);
        step(1'b0);
`ifdef SPRITE_ARB_HFLIP_EN
        set_req(0, 0, 0, 0, 1'b1);
        step(1'b0);
`endif
        repeat (3) step(1'b0);

        // Reset while a read is in flight: response dropped, pointer back to 0.
        set_req(0, 1, 1, 1, 1'b0);
        step(1'b0);
        Reset = 1'b1;
        exp_q.delete();
        exp_t_q.delete();
        m_ptr = 0;
        set_req(0, 0, 4, 4, 1'b0);
        set_req(1, 1, 6, 6, 1'b0);
        drive();
        #1;
        check("gnt_in_reset", 32'(gnt), 32'(0));
        @(negedge Clk);
        Reset = 1'b0;
        step(1'b0);
        tb_req = '0;
        repeat (3) step(1'b0);

        // Randomized traffic.
        repeat (400) begin
            for (int i = 0; i < N_REQ; i++)
                if (!tb_req[i] && $urandom_range(0, 3) != 0)
                    set_req(i, $urandom_range(0, 3), $urandom_range(0, SPR_W - 1),
                            $urandom_range(0, SPR_H - 1), 1'($urandom_range(0, 1)));
            step(1'b0);
        end
        tb_req = '0;
        repeat (4) step(1'b0);
        check("queue_drained", 32'(exp_q.size()), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sprite_rom_arbiter.md
# sprite_rom_arbiter

Shares one synchronous-read sprite ROM (1536 entries × 4-bit palette index, one-cycle read latency) between several sprite renderers. Each requester supplies a frame index and pixel coordinate; the block arbitrates round-robin, computes the linear ROM address, issues at most one ROM read per cycle and returns the pixel tagged to the winning requester. It sits between the per-object draw logic and the single ROM instance in the sprite subsystem.

## Interface
Parameters:
- N_REQ, 2, number of requesters
- SPR_W, 32, sprite width in pixels (power of two)
- SPR_H, 16, sprite height in pixels (power of two)
- N_FRAMES, 3, frames stored back to back in the ROM
- ADDR_W, 11, ROM address width
- DATA_W, 4, ROM data width

Ports (FW = clog2(N_FRAMES), XW = clog2(SPR_W), YW = clog2(SPR_H)):
- Clk  in  1  system clock; only clock
- Reset  in  1  synchronous, active-high reset
- req  in  N_REQ  request valid, one bit per requester
- gnt  out  N_REQ  combinational accept, one-hot or zero
- req_frame  in  N_REQ*FW  frame index, requester i at slice i
- req_x  in  N_REQ*XW  pixel column
- req_y  in  N_REQ*YW  pixel row
- rom_addr  out  ADDR_W  registered ROM read address
- rom_data  in  DATA_W  ROM read data (valid one cycle after rom_addr)
- rsp_valid  out  N_REQ  one-hot response strobe
- rsp_data  out  DATA_W  pixel value for the strobed requester
- rsp_err  out  1  response belongs to an out-of-range request

## Operation
- Handshake: transfer on the rising edge where req[i] & gnt[i]. Requester holds req and fields stable until accepted; req may stay high for back-to-back transfers.
- gnt: combinational; grants the first asserted req at or after rr_ptr, wrapping modulo N_REQ. Zero when req == 0. Never depends on rsp state (no backpressure).
- rr_ptr: on a transfer by i, becomes (i+1) mod N_REQ; unchanged on idle cycles. Reset value 0.
- Address: frame*(SPR_W*SPR_H) + y*SPR_W + x, computed at full width then truncated to ADDR_W; with defaults max 1535.
- Range check: frame ≥ N_FRAMES, x ≥ SPR_W or y ≥ SPR_H → request still accepted, rom_addr loaded with 0, response carries rsp_data = 0 and rsp_err = 1.
- Pipeline: stage 1 registers rom_addr, tag (winner index), valid, err; stage 2 registers rsp_valid = onehot(tag) & valid, rsp_err. rsp_data = rom_data, or 0 when err, combinational from stage-2 err.
- Reset values: rom_addr 0, rsp_valid 0, rsp_err 0, rr_ptr 0, all pipeline valids 0; rsp_data therefore follows rom_data but is qualified only by rsp_valid.
- Reset mid-operation: in-flight reads are discarded; no rsp_valid asserted in the cycle after Reset deasserts. gnt is 0 while Reset is high.

## Timing
- Accept at edge E0 → rom_addr valid after E0 → ROM samples at E1 → rsp_valid/rsp_data valid in cycle after E1 (2-cycle latency).
- Throughput: one transfer per cycle sustained; responses return in accept order.
- rsp_valid is a single-cycle pulse per transfer.

## Configuration
- SPRITE_ARB_HFLIP_EN defined: adds input req_hflip (N_REQ bits); when set, column used is SPR_W-1-x (range check applied to unflipped x).
- Undefined: req_hflip port absent; column is x as given.

## Structure
- Shared package sprite_pkg: SPR_W, SPR_H, N_FRAMES, FRAME_SIZE constant, ROM depth, pixel typedef (DATA_W-bit), transparent-colour constant 0.
- One sub-module: rr_arbiter (N_REQ parameter; req, rr_ptr in → gnt one-hot, winner index out).

## Test plan
- Single request: req[0], frame 1, x 5, y 2 → rom_addr 581 next cycle; rsp_valid = 01, rsp_data = mem[581] two cycles after accept.
- Contention: req = 11 held 4 cycles from reset → gnt 01,10,01,10; rsp_valid same pattern 2 cycles later.
- Range: frame 3 (or x 32 via wider test override, or y 16) → accepted, rsp_data 0, rsp_err 1, rom_addr 0.
- Max address: frame 2, x 31, y 15 → rom_addr 1535, no err.
- Reset mid-flight: accept at E0, Reset high across E1 → no rsp_valid, rr_ptr 0 afterwards.
- With SPRITE_ARB_HFLIP_EN: frame 0, x 0, y 0, hflip 1 → rom_addr 31.
